// File: rtl/pmod_seconds_rx.sv
// Receiver for the BCD seconds link on a PMOD header: resync, glitch filter, BCD and sequence checks, lock.
// Optional inter-update period measurement is built when PMOD_SECONDS_RX_PERIOD_MEAS_EN is defined.
module pmod_seconds_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int LOCK_COUNT    = 3,
    parameter int PERIOD_W      = 26
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          pmod_in,
    output logic [3:0]          seconds_lo,
    output logic [3:0]          seconds_hi,
    output logic                update,
    output logic                seq_error,
    output logic                bcd_error,
    output logic                locked,
    output logic [PERIOD_W-1:0] period
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_TRACK,
        ST_LOCKED
    } state_t;

    // Returns {hi, lo}; each nibble arrives bit-reversed on the header.
    function automatic logic [7:0] unscramble(input logic [7:0] s);
        return {s[4], s[5], s[6], s[7], s[0], s[1], s[2], s[3]};
    endfunction

    function automatic logic bcd_legal(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
    endfunction

    function automatic logic [7:0] bcd_succ(input logic [7:0] v);
        logic [3:0] lo_n;
        logic [3:0] hi_n;
        lo_n = v[3:0] + 4'd1;
        hi_n = v[7:4] + 4'd1;
        if (v[3:0] < 4'd9)
            return {v[7:4], lo_n};
        else if (v[7:4] >= 4'd5)
            return 8'h00;
        else
            return {hi_n, 4'd0};
    endfunction

    logic [7:0]    sync_p0, sync_p1;
    logic [7:0]    digits_p1;
    logic [7:0]    cand_p2;
    logic [SW-1:0] stab_cnt;
    logic          have_value;
    logic          evt;
    logic [7:0]    cur_val;

    state_t     state_q, state_d;
    logic [3:0] good_q, good_d;
    logic       locked_d, upd_d, seq_d, bcd_d, load_d;

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pmod_in;
            sync_p1 <= sync_p0;
        end
    end

    assign digits_p1 = unscramble(sync_p1);

    // Stage p2: stability filter, saturating at STABLE_CYCLES so each value fires once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_p2  <= '0;
            stab_cnt <= '0;
        end else if (digits_p1 != cand_p2) begin
            cand_p2  <= digits_p1;
            stab_cnt <= SW'(1);
        end else if (stab_cnt != SW'(STABLE_CYCLES)) begin
            stab_cnt <= stab_cnt + SW'(1);
        end
    end

    assign cur_val = {seconds_hi, seconds_lo};
    assign evt     = (digits_p1 == cand_p2) && (stab_cnt == SW'(STABLE_CYCLES - 1)) &&
                     (!have_value || (cand_p2 != cur_val));

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        locked_d = locked;
        upd_d    = 1'b0;
        seq_d    = 1'b0;
        bcd_d    = 1'b0;
        load_d   = 1'b0;
        if (evt) begin
            if (!bcd_legal(cand_p2)) begin
                bcd_d    = 1'b1;
                state_d  = ST_SEARCH;
                good_d   = 4'd0;
                locked_d = 1'b0;
            end else begin
                upd_d  = 1'b1;
                load_d = 1'b1;
                case (state_q)
                    ST_SEARCH: begin
                        state_d  = ST_TRACK;
                        good_d   = 4'd0;
                        locked_d = 1'b0;
                    end
                    ST_TRACK: begin
                        if (cand_p2 == bcd_succ(cur_val)) begin
                            good_d = good_q + 4'd1;
                            if (good_q + 4'd1 == 4'(LOCK_COUNT)) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            seq_d  = 1'b1;
                            good_d = 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (cand_p2 != bcd_succ(cur_val)) begin
                            seq_d    = 1'b1;
                            locked_d = 1'b0;
                            good_d   = 4'd0;
                            state_d  = ST_TRACK;
                        end
                    end
                    default: begin
                        state_d  = ST_SEARCH;
                        good_d   = 4'd0;
                        locked_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Stage p3: registered outputs and FSM state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SEARCH;
            good_q     <= '0;
            locked     <= 1'b0;
            update     <= 1'b0;
            seq_error  <= 1'b0;
            bcd_error  <= 1'b0;
            have_value <= 1'b0;
            seconds_lo <= '0;
            seconds_hi <= '0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            locked    <= locked_d;
            update    <= upd_d;
            seq_error <= seq_d;
            bcd_error <= bcd_d;
            if (load_d) begin
                have_value <= 1'b1;
                seconds_lo <= cand_p2[3:0];
                seconds_hi <= cand_p2[7:4];
            end
        end
    end

`ifdef PMOD_SECONDS_RX_PERIOD_MEAS_EN
    logic [PERIOD_W-1:0] per_cnt;

    // Acceptance from SEARCH restarts timing but has no previous update to measure against
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt <= '0;
            period  <= '0;
        end else begin
            if (load_d)
                per_cnt <= PERIOD_W'(1);
            else if (per_cnt != '1)
                per_cnt <= per_cnt + PERIOD_W'(1);
            if (load_d && (state_q != ST_SEARCH))
                period <= per_cnt;
        end
    end
`else
    assign period = '0;
`endif

endmodule

// File: tb/tb_pmod_seconds_rx.sv
// Bench for pmod_seconds_rx: vector table through a scoreboard, plus filter, period and reset sequences.
module tb_pmod_seconds_rx;

    localparam int PW = 26;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    pmod_in;
    logic [3:0]    seconds_lo, seconds_hi;
    logic          update, seq_error, bcd_error, locked;
    logic [PW-1:0] period;

    pmod_seconds_rx #(.STABLE_CYCLES(4), .LOCK_COUNT(3), .PERIOD_W(PW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pmod_in    (pmod_in),
        .seconds_lo (seconds_lo),
        .seconds_hi (seconds_hi),
        .update     (update),
        .seq_error  (seq_error),
        .bcd_error  (bcd_error),
        .locked     (locked),
        .period     (period)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       upd;
        logic       seq;
        logic       bcd;
        logic       lock;
    } exp_t;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   pulse_cnt = 0;
    vec_t vecs[17];

    function automatic logic [7:0] scr(input logic [3:0] hi, input logic [3:0] lo);
        return {hi[0], hi[1], hi[2], hi[3], lo[0], lo[1], lo[2], lo[3]};
    endfunction

    function automatic vec_t mk(input logic [3:0] hi, input logic [3:0] lo,
                                input logic [3:0] ehi, input logic [3:0] elo,
                                input logic upd, input logic seq, input logic bcd, input logic lock);
        vec_t v;
        v.hi = hi;
        v.lo = lo;
        v.e  = '{hi: ehi, lo: elo, upd: upd, seq: seq, bcd: bcd, lock: lock};
        return v;
    endfunction

    // Every pulse cycle consumes one expected record
    always @(negedge clk) begin
        if (reset_n && (update || seq_error || bcd_error)) begin
            exp_t e;
            pulse_cnt++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse got upd=%b seq=%b bcd=%b val=%0d%0d, required no pulse",
                         update, seq_error, bcd_error, seconds_hi, seconds_lo);
            end else begin
                e = sb.pop_front();
                if (seconds_hi !== e.hi || seconds_lo !== e.lo || update !== e.upd ||
                    seq_error !== e.seq || bcd_error !== e.bcd || locked !== e.lock) begin
                    fails++;
                    $display("FAIL out_check got val=%0d%0d upd=%b seq=%b bcd=%b lock=%b, required val=%0d%0d upd=%b seq=%b bcd=%b lock=%b",
                             seconds_hi, seconds_lo, update, seq_error, bcd_error, locked,
                             e.hi, e.lo, e.upd, e.seq, e.bcd, e.lock);
                end
            end
        end
    end

    task automatic wait_drain(output int lat);
        lat = 0;
        while (sb.size() != 0 && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout got %0d pending records after %0d cycles, required 0", sb.size(), lat);
            sb.delete();
        end
    endtask

    task automatic apply(input vec_t v, output int lat);
        sb.push_back(v.e);
        pmod_in = scr(v.hi, v.lo);
        wait_drain(lat);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        int lat;
        int base;

        vecs[0]  = mk(0, 1, 0, 1, 1, 0, 0, 0);
        vecs[1]  = mk(0, 2, 0, 2, 1, 0, 0, 0);
        vecs[2]  = mk(0, 3, 0, 3, 1, 0, 0, 1);
        vecs[3]  = mk(0, 4, 0, 4, 1, 0, 0, 1);
        vecs[4]  = mk(5, 5, 5, 5, 1, 1, 0, 0);
        vecs[5]  = mk(5, 6, 5, 6, 1, 0, 0, 0);
        vecs[6]  = mk(5, 7, 5, 7, 1, 0, 0, 0);
        vecs[7]  = mk(5, 8, 5, 8, 1, 0, 0, 1);
        vecs[8]  = mk(5, 9, 5, 9, 1, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 1);
        vecs[10] = mk(0, 5, 0, 5, 1, 1, 0, 0);
        vecs[11] = mk(0, 6, 0, 6, 1, 0, 0, 0);
        vecs[12] = mk(0, 4'hA, 0, 6, 0, 0, 1, 0);
        vecs[13] = mk(0, 7, 0, 7, 1, 0, 0, 0);
        vecs[14] = mk(3, 0, 3, 0, 1, 1, 0, 0);
        vecs[15] = mk(6, 0, 3, 0, 0, 0, 1, 0);
        vecs[16] = mk(3, 1, 3, 1, 1, 0, 0, 0);

        reset_n = 1'b0;
        pmod_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", {seconds_hi, seconds_lo, update, seq_error, bcd_error, locked, period}, '0);

        // First stable 00 after reset must still be reported
        sb.push_back('{hi: 0, lo: 0, upd: 1, seq: 0, bcd: 0, lock: 0});
        reset_n = 1'b1;
        wait_drain(lat);

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i], lat);
            if (i == 0) check("pin_to_update_latency", lat, 6);
            if (vecs[i].e.bcd) begin
                repeat (8) @(negedge clk);
                check("bcd_hold_outputs", {seconds_hi, seconds_lo, locked}, {vecs[i].e.hi, vecs[i].e.lo, 1'b0});
            end
        end

        // Bit 0 chatter shorter than the filter window must produce nothing
        base = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            pmod_in = pmod_in ^ 8'h01;
            repeat (2) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("glitch_no_pulse", pulse_cnt - base, 0);

        for (int k = 0; k < 4; k++) begin
            sb.push_back('{hi: 3, lo: 4'(2 + k), upd: 1, seq: 0, bcd: 0, lock: (k >= 2)});
            pmod_in = scr(4'd3, 4'(2 + k));
            repeat (1000) @(negedge clk);
`ifdef PMOD_SECONDS_RX_PERIOD_MEAS_EN
            if (k >= 1) check("period_1000", period, 1000);
`else
            check("period_tied_zero", period, 0);
`endif
        end
        check("period_seq_drained", sb.size(), 0);
        sb.delete();

        // Reset during a partial filter count
        pmod_in = scr(4'd3, 4'd6);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", {seconds_hi, seconds_lo, update, seq_error, bcd_error, locked, period}, '0);
        repeat (2) @(negedge clk);
        sb.push_back('{hi: 3, lo: 6, upd: 1, seq: 0, bcd: 0, lock: 0});
        reset_n = 1'b1;
        wait_drain(lat);
        check("post_reset_latency", lat, 6);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish, required finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
